pwm_apb_regs: RTL and testbench
===============================

# pwm_apb_regs

APB3 slave register block that sits directly upstream of the PWM channels. It decodes bus writes into the per-channel period, duty and control registers and drives the channels' shared data buses and one-hot write strobes. It keeps shadow copies of all channel registers for readback. Double buffering and rollover-synchronised loading stay inside each channel; this block only delivers write pulses.

## Interface
- NUM_CHANNELS, 4, number of PWM channels served (legal 1..8)
- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-low
- psel  in  1  APB select
- penable  in  1  APB enable (access phase)
- pwrite  in  1  1 = write, 0 = read
- paddr  in  12  byte address
- pwdata  in  32  write data
- prdata  out  32  read data, valid while pready=1
- pready  out  1  transfer-complete, high only in ACCESS state
- pslverr  out  1  error response, valid while pready=1
- period_out  out  32  shared period bus to all channels
- duty_out  out  32  shared duty bus to all channels
- control_out  out  3  shared control bus {alignment, polarity, enable}
- period_wen  out  NUM_CHANNELS  one-hot period write strobe
- duty_wen  out  NUM_CHANNELS  one-hot duty write strobe
- cont_wen  out  NUM_CHANNELS  one-hot control write strobe

## Operation
- Address map: channel n base = n*0x10.
  - +0x0 PERIOD (32b RW)
  - +0x4 DUTY (32b RW)
  - +0x8 CONTROL (bits 2:0 RW, bits 31:3 read 0, bit0 enable, bit1 polarity, bit2 alignment 0=left/1=center)
  - 0x100 ID (RO) = 0x50574D00 | NUM_CHANNELS
- Error (pslverr=1, prdata=0, no register or strobe change) for any of:
  - paddr[1:0] != 0
  - channel index >= NUM_CHANNELS
  - offset 0xC
  - write to ID
  - any other unmapped address
- FSM states: IDLE, ACCESS.
  - IDLE: when psel=1 and penable=0 (setup phase), register decoded target, pwrite, pwdata, error flag and read data; go to ACCESS.
  - ACCESS: pready=1, registered prdata/pslverr presented. If psel=1 and penable=1, the transfer commits at the clock edge ending this cycle; then go to IDLE.
  - Protocol violation (in ACCESS with psel=0 or penable=0): abort, no commit, no strobe, go to IDLE.
- A committed non-error write updates the shadow register and, in the next cycle, drives the matching data bus plus exactly one strobe bit for one cycle.
  - Only the bus of the written register type changes; other buses hold their last value.
  - CONTROL writes keep pwdata[2:0] only.
- Duty > period and zero values are stored as written; no range checks.
- Reads never disturb shadows, buses or strobes.

## Timing
- Reset values: prdata=0, pready=0, pslverr=0, all buses 0, all strobes 0, all shadows 0, state IDLE.
- Cycle T: setup phase. T+1: access phase, pready=1. T+2: strobe high (write only). T+3: strobe low.
- Zero wait states; every transfer takes 2 cycles. Back-to-back transfers allowed: a new setup in T+2 is accepted from IDLE.
- A strobe in T+2 can coincide with the next transfer's setup without interaction.
- Readback of a register written in transfer k returns the new value in transfer k+1.
- Reset asserted mid-transfer: immediate return to reset values; a pending write is lost and no strobe is emitted.
- pslverr and prdata are 0 whenever pready=0.

## Test plan
- Reset: assert n_rst low mid-ACCESS of a write to 0x000 -> all outputs 0, no period_wen pulse after release, readback of 0x000 = 0.
- Write 0x000=100, 0x004=25, 0x008=0x5 -> period_out=100 with period_wen=0001 for one cycle at T+2; likewise duty_out=25/duty_wen=0001 and control_out=3'b101/cont_wen=0001; reads return 100, 25, 0x5.
- Write 0x038=0xFFFFFFFF (ch3 CONTROL) -> control_out=3'b111, cont_wen=1000; read 0x038 = 0x00000007.
- Error cases (NUM_CHANNELS=4): write 0x040, write 0x00C, write 0x002, write 0x100 -> each gives pslverr=1 with pready, no strobes, shadows unchanged; read 0x100 = 0x50574D04, pslverr=0.
- Back-to-back writes 0x014=7 then 0x024=9 with no idle cycle -> period_wen=0010 then 0100 on consecutive transfer strobe cycles, period_out 7 then 9.
- Aborted access: setup write 0x004=55, then drop psel in the access cycle -> no duty_wen, read 0x004 unchanged.

Source files
------------

// File: rtl/pwm_apb_regs.sv
// pwm_apb_regs: APB3 register block driving PWM channel period/duty/control buses and one-hot write strobes
// clk, n_rst (async, active-low); APB3 slave psel/penable/pwrite/paddr/pwdata -> prdata/pready/pslverr;
// period_out/duty_out/control_out shared channel buses; period_wen/duty_wen/cont_wen one-hot strobes
module pwm_apb_regs #(
  parameter int NUM_CHANNELS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [11:0]             paddr,
  input  logic [31:0]             pwdata,
  output logic [31:0]             prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic [31:0]             period_out,
  output logic [31:0]             duty_out,
  output logic [2:0]              control_out,
  output logic [NUM_CHANNELS-1:0] period_wen,
  output logic [NUM_CHANNELS-1:0] duty_wen,
  output logic [NUM_CHANNELS-1:0] cont_wen
);
  localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [31:0] ID = 32'h50574D00 | 32'(NUM_CHANNELS);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t r_state, w_next;
  logic r_write, r_err;
  logic [1:0] r_type;
  logic [CW-1:0] r_ch;
  logic [31:0] r_wdata, r_prdata;
  logic [31:0] r_period [NUM_CHANNELS];
  logic [31:0] r_duty [NUM_CHANNELS];
  logic [2:0] r_ctrl [NUM_CHANNELS];
  logic [CW-1:0] w_ch;
  logic w_chv, w_id, w_err, w_setup, w_commit;
  logic [31:0] w_rdata;
  logic [NUM_CHANNELS-1:0] w_onehot;
  assign w_ch = paddr[4 +: CW];
  assign w_chv = paddr[11:4] < 8'(NUM_CHANNELS);
  assign w_id = paddr == 12'h100;
  // ID is the only mapped address outside the channel window and is read-only
  assign w_err = (|paddr[1:0]) || (w_id ? pwrite : !(w_chv && paddr[3:2] != 2'd3));
  assign w_rdata = w_err ? '0 : w_id ? ID : paddr[3:2] == 2'd0 ? r_period[w_ch] :
                   paddr[3:2] == 2'd1 ? r_duty[w_ch] : {29'b0, r_ctrl[w_ch]};
  assign w_setup = r_state == IDLE && psel && !penable;
  assign w_commit = r_state == ACCESS && psel && penable && r_write && !r_err;
  assign w_onehot = NUM_CHANNELS'(1) << r_ch;
  assign pready = r_state == ACCESS;
  assign prdata = pready ? r_prdata : '0;
  assign pslverr = pready && r_err;
  always_comb w_next = w_setup ? ACCESS : IDLE;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      r_write <= 1'b0;
      r_err <= 1'b0;
      r_type <= '0;
      r_ch <= '0;
      r_wdata <= '0;
      r_prdata <= '0;
      period_out <= '0;
      duty_out <= '0;
      control_out <= '0;
      period_wen <= '0;
      duty_wen <= '0;
      cont_wen <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_period[i] <= '0;
        r_duty[i] <= '0;
        r_ctrl[i] <= '0;
      end
    end else begin
      if (w_setup) begin
        r_write <= pwrite;
        r_err <= w_err;
        r_type <= paddr[3:2];
        r_ch <= w_ch;
        r_wdata <= pwdata;
        r_prdata <= pwrite ? '0 : w_rdata;
      end
      period_wen <= (w_commit && r_type == 2'd0) ? w_onehot : '0;
      duty_wen <= (w_commit && r_type == 2'd1) ? w_onehot : '0;
      cont_wen <= (w_commit && r_type == 2'd2) ? w_onehot : '0;
      if (w_commit && r_type == 2'd0) begin
        r_period[r_ch] <= r_wdata;
        period_out <= r_wdata;
      end
      if (w_commit && r_type == 2'd1) begin
        r_duty[r_ch] <= r_wdata;
        duty_out <= r_wdata;
      end
      if (w_commit && r_type == 2'd2) begin
        r_ctrl[r_ch] <= r_wdata[2:0];
        control_out <= r_wdata[2:0];
      end
    end
endmodule

// File: tb/tb_pwm_apb_regs.sv
// tb_pwm_apb_regs: self-checking bench for pwm_apb_regs against a register-map model
module tb_pwm_apb_regs;
  localparam int NUM = 4;
  localparam logic [31:0] ID = 32'h50574D04;
  logic clk = 1'b0, n_rst = 1'b0, psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata, period_out, duty_out;
  logic pready, pslverr;
  logic [2:0] control_out;
  logic [NUM-1:0] period_wen, duty_wen, cont_wen;
  int tests = 0, fails = 0, cyc = 0;
  int stb_cyc = -1;
  logic [1:0] stb_type = '0;
  logic [2:0] stb_ch = '0;
  logic [31:0] stb_data = '0;
  bit mon_en = 1'b0;
  logic [31:0] m_period [NUM];
  logic [31:0] m_duty [NUM];
  logic [2:0] m_ctrl [NUM];
  logic [31:0] m_pbus = '0, m_dbus = '0;
  logic [2:0] m_cbus = '0;
  pwm_apb_regs #(.NUM_CHANNELS(NUM)) dut (
    .clk(clk), .n_rst(n_rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .period_out(period_out), .duty_out(duty_out), .control_out(control_out),
    .period_wen(period_wen), .duty_wen(duty_wen), .cont_wen(cont_wen)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin : mon
    logic hit;
    logic [NUM-1:0] oh, ep, ed, ec;
    if (mon_en) begin
      hit = cyc == stb_cyc;
      oh = NUM'(1) << stb_ch;
      ep = (hit && stb_type == 2'd0) ? oh : '0;
      ed = (hit && stb_type == 2'd1) ? oh : '0;
      ec = (hit && stb_type == 2'd2) ? oh : '0;
      if (hit && stb_type == 2'd0) m_pbus = stb_data;
      if (hit && stb_type == 2'd1) m_dbus = stb_data;
      if (hit && stb_type == 2'd2) m_cbus = stb_data[2:0];
      tests++;
      if (period_wen !== ep || duty_wen !== ed || cont_wen !== ec) begin
        fails++;
        $display("FAIL strobes cyc %0d: got p=%b d=%b c=%b want p=%b d=%b c=%b", cyc, period_wen, duty_wen, cont_wen, ep, ed, ec);
      end
      tests++;
      if (period_out !== m_pbus || duty_out !== m_dbus || control_out !== m_cbus) begin
        fails++;
        $display("FAIL buses cyc %0d: got p=%h d=%h c=%b want p=%h d=%h c=%b", cyc, period_out, duty_out, control_out, m_pbus, m_dbus, m_cbus);
      end
    end
  end
  function automatic bit exp_err(input logic [11:0] a, input bit w);
    if (a[1:0] != 2'd0) return 1'b1;
    if (a == 12'h100) return w;
    return !(a < 12'(NUM * 16) && a[3:2] != 2'd3);
  endfunction
  function automatic logic [31:0] exp_rd(input logic [11:0] a);
    if (a == 12'h100) return ID;
    if (a[3:2] == 2'd0) return m_period[a[5:4]];
    if (a[3:2] == 2'd1) return m_duty[a[5:4]];
    return {29'b0, m_ctrl[a[5:4]]};
  endfunction
  task automatic apb(input bit w, input logic [11:0] a, input logic [31:0] d, input bit abort);
    bit e;
    logic [31:0] r;
    e = exp_err(a, w);
    r = (e || w) ? 32'h0 : exp_rd(a);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(negedge clk);
    tests++;
    if (pready !== 1'b0 || prdata !== 32'h0 || pslverr !== 1'b0) begin
      fails++;
      $display("FAIL setup_phase %h: got rdy=%b rd=%h err=%b want 0 0 0", a, pready, prdata, pslverr);
    end
    @(posedge clk) #1;
    if (abort) begin psel = 1'b0; penable = 1'b0; end
    else penable = 1'b1;
    @(negedge clk);
    tests++;
    if (pready !== 1'b1 || pslverr !== e || (!w && prdata !== r)) begin
      fails++;
      $display("FAIL access %s %h: got rdy=%b err=%b rd=%h want 1 %b %h", w ? "wr" : "rd", a, pready, pslverr, prdata, e, r);
    end
    if (!abort && w && !e) begin
      if (a[3:2] == 2'd0) m_period[a[5:4]] = d;
      if (a[3:2] == 2'd1) m_duty[a[5:4]] = d;
      if (a[3:2] == 2'd2) m_ctrl[a[5:4]] = d[2:0];
      stb_cyc = cyc + 1; stb_type = a[3:2]; stb_ch = 3'(a[5:4]); stb_data = d;
    end
    @(posedge clk) #1;
    psel = 1'b0; penable = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk) #1;
  endtask
  task automatic test_reset;
    for (int i = 0; i < NUM; i++) begin m_period[i] = '0; m_duty[i] = '0; m_ctrl[i] = '0; end
    #2;
    tests++;
    if ({prdata, pready, pslverr, period_out, duty_out, control_out, period_wen, duty_wen, cont_wen} !== '0) begin
      fails++;
      $display("FAIL reset_values: got rd=%h rdy=%b err=%b p=%h d=%h c=%b want all 0", prdata, pready, pslverr, period_out, duty_out, control_out);
    end
    @(negedge clk) n_rst = 1'b1;
    mon_en = 1'b1;
    @(posedge clk) #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'hABCD;
    @(posedge clk) #1;
    penable = 1'b1;
    #2 n_rst = 1'b0;
    #1;
    tests++;
    if ({prdata, pready, pslverr, period_out, period_wen, duty_wen, cont_wen} !== '0) begin
      fails++;
      $display("FAIL reset_mid_access: got rd=%h rdy=%b err=%b p=%h pw=%b want all 0", prdata, pready, pslverr, period_out, period_wen);
    end
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk) #1;
    psel = 1'b0; penable = 1'b0;
    idle(3);
    apb(1'b0, 12'h000, 32'h0, 1'b0);
  endtask
  task automatic test_basic;
    apb(1'b1, 12'h000, 32'd100, 1'b0); idle(1);
    apb(1'b1, 12'h004, 32'd25, 1'b0); idle(1);
    apb(1'b1, 12'h008, 32'h5, 1'b0); idle(1);
    apb(1'b0, 12'h000, 32'h0, 1'b0);
    apb(1'b0, 12'h004, 32'h0, 1'b0);
    apb(1'b0, 12'h008, 32'h0, 1'b0);
    tests++;
    if (period_out !== 32'd100 || duty_out !== 32'd25 || control_out !== 3'b101) begin
      fails++;
      $display("FAIL basic_buses: got p=%0d d=%0d c=%b want 100 25 101", period_out, duty_out, control_out);
    end
    idle(1);
  endtask
  task automatic test_ch3_control;
    apb(1'b1, 12'h038, 32'hFFFFFFFF, 1'b0);
    apb(1'b0, 12'h038, 32'h0, 1'b0);
    tests++;
    if (control_out !== 3'b111 || m_ctrl[3] !== 3'b111) begin
      fails++;
      $display("FAIL ch3_control: got %b want 111", control_out);
    end
    idle(1);
  endtask
  task automatic test_errors;
    apb(1'b1, 12'h040, 32'h11, 1'b0); idle(1);
    apb(1'b1, 12'h00C, 32'h22, 1'b0); idle(1);
    apb(1'b1, 12'h002, 32'h33, 1'b0); idle(1);
    apb(1'b1, 12'h100, 32'h44, 1'b0); idle(1);
    apb(1'b0, 12'h100, 32'h0, 1'b0);
    apb(1'b0, 12'h000, 32'h0, 1'b0);
    apb(1'b0, 12'h004, 32'h0, 1'b0);
    apb(1'b0, 12'h0FC, 32'h0, 1'b0);
    idle(1);
  endtask
  task automatic test_back_to_back;
    apb(1'b1, 12'h014, 32'd7, 1'b0);
    apb(1'b1, 12'h024, 32'd9, 1'b0);
    apb(1'b0, 12'h014, 32'h0, 1'b0);
    apb(1'b0, 12'h024, 32'h0, 1'b0);
    idle(1);
  endtask
  task automatic test_abort;
    apb(1'b1, 12'h004, 32'd55, 1'b1); idle(2);
    apb(1'b0, 12'h004, 32'h0, 1'b0);
    idle(1);
  endtask
  task automatic test_random;
    for (int i = 0; i < 200; i++) begin
      logic [11:0] a;
      int k;
      k = int'($urandom_range(0, 9));
      a = k < 6 ? {6'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), 2'b00} :
          k == 6 ? 12'h100 : k == 7 ? {6'b0, 2'($urandom_range(0, 3)), 4'hC} : 12'($urandom);
      apb(1'($urandom), a, $urandom, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
    end
    idle(2);
  endtask
  initial begin
    test_reset;
    test_basic;
    test_ch3_control;
    test_errors;
    test_back_to_back;
    test_abort;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
